// File: rtl/conv_out_collector_if.sv
// rtl/conv_out_collector_if.sv - result stream bundle between the collector and its downstream consumer
//
// Purpose: groups the valid/ready result stream leaving conv_out_collector.
// Signals:
//   out_data  : FIFO head sample
//   out_valid : out_data holds a valid sample
//   out_ready : consumer accepts when out_valid && out_ready
//   out_last  : head sample is the final sample of the frame
// Modports: master (collector side), slave (consumer side).

interface conv_out_collector_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/conv_out_collector.sv
// rtl/conv_out_collector.sv - drains the systolic conv array y stream into a small output FIFO
//
// Purpose: discards the first SKIP y samples of a frame (array fill latency),
// collects the next FRAME_LEN samples into a FIFO_DEPTH-entry buffer and
// presents them on a valid/ready stream with end-of-frame marking.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : begin a frame (only honoured while idle)
//   y_in       : y sample from the last PE
//   y_valid    : y_in holds a new sample this cycle
//   out_if     : result stream (out_data/out_valid/out_ready/out_last)
//   busy       : a frame is in progress
//   overflow   : sticky, a result was dropped because the FIFO was full

module conv_out_collector #(
    parameter int DATA_W     = 16,
    parameter int SKIP       = 2,
    parameter int FRAME_LEN  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    y_in,
    input  logic                 y_valid,
    conv_out_collector_if.master out_if,
    output logic                 busy,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SKIP + FRAME_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   skip_cnt_q, skip_cnt_d;
    logic [CW-1:0]   collect_cnt_q, collect_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;

    // Each entry carries {last, data}.
    logic [DATA_W:0] mem_q [FIFO_DEPTH];

    logic empty, full, pop, push_try, push_last, push_ok;

    // FIFO control. A push into a full FIFO still succeeds when the head is
    // popped in the same cycle, because the freed slot is the one written.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == (AW+1)'(FIFO_DEPTH));
        pop        = !empty && out_if.out_ready;
        push_try   = (state_q == S_COLLECT) && y_valid;
        push_last  = (collect_cnt_q == CW'(FRAME_LEN - 1));
        push_ok    = push_try && (!full || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (push_try && full && !pop);

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
    end

    // Frame sequencing.
    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        collect_cnt_d = collect_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    skip_cnt_d    = '0;
                    collect_cnt_d = '0;
                    state_d       = (SKIP == 0) ? S_COLLECT : S_SKIP;
                end
            end
            S_SKIP: begin
                if (y_valid) begin
                    skip_cnt_d = skip_cnt_q + CW'(1);
                    if (skip_cnt_q == CW'(SKIP - 1)) state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Dropped samples still count toward the frame length.
                if (y_valid) begin
                    collect_cnt_d = collect_cnt_q + CW'(1);
                    if (push_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looks at the post-pop count so the final pop and the
                // return to idle share a cycle.
                if (count_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            skip_cnt_q    <= '0;
            collect_cnt_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            collect_cnt_q <= collect_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= {push_last, y_in};
    end

    always_comb begin
        out_if.out_valid = !empty;
        out_if.out_data  = empty ? '0 : mem_q[rd_ptr_q][DATA_W-1:0];
        out_if.out_last  = !empty && mem_q[rd_ptr_q][DATA_W];
        busy             = (state_q != S_IDLE);
        overflow         = overflow_q;
    end
endmodule

// File: tb/tb_conv_out_collector.sv
// tb/tb_conv_out_collector.sv - directed self-checking bench for conv_out_collector

module tb_conv_out_collector;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] y_in;
    logic        y_valid;
    logic        out_ready;
    logic        busy0, ovf0, busy1, ovf1;

    int errors = 0;
    int checks = 0;

    int got0_d[$];
    bit got0_l[$];
    int got1_d[$];
    bit got1_l[$];
    int exp_d[$];
    bit exp_l[$];

    conv_out_collector_if #(.DATA_W(16)) o0 ();
    conv_out_collector_if #(.DATA_W(16)) o1 ();

    assign o0.out_ready = out_ready;
    assign o1.out_ready = out_ready;

    conv_out_collector #(.DATA_W(16), .SKIP(2), .FRAME_LEN(8), .FIFO_DEPTH(4)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y_in     (y_in),
        .y_valid  (y_valid),
        .out_if   (o0),
        .busy     (busy0),
        .overflow (ovf0)
    );

    conv_out_collector #(.DATA_W(16), .SKIP(0), .FRAME_LEN(8), .FIFO_DEPTH(4)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y_in     (y_in),
        .y_valid  (y_valid),
        .out_if   (o1),
        .busy     (busy1),
        .overflow (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change 1 time unit after a rising edge, so the falling
    // edge sees exactly the handshake that the next rising edge completes.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (o0.out_valid) begin
                got0_d.push_back(int'(o0.out_data));
                got0_l.push_back(o0.out_last);
            end
            if (o1.out_valid) begin
                got1_d.push_back(int'(o1.out_data));
                got1_l.push_back(o1.out_last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int last_v, input bit gaps);
        for (int v = first; v <= last_v; v++) begin
            y_in    = 16'(v);
            y_valid = 1'b1;
            tick();
            if (gaps) begin
                y_valid = 1'b0;
                tick();
            end
        end
        y_valid = 1'b0;
    endtask

    task automatic build_exp(input int first, input int last_v, input int last_mark);
        exp_d.delete();
        exp_l.delete();
        for (int v = first; v <= last_v; v++) begin
            exp_d.push_back(v);
            exp_l.push_back(v == last_mark);
        end
    endtask

    // Waits for dut0 to go idle; the handshake carrying out_last must be
    // followed immediately by busy=0.
    task automatic drain0(input string tag);
        bit hs;
        for (int i = 0; i < 40; i++) begin
            if (!busy0) break;
            hs = o0.out_valid && out_ready && o0.out_last;
            tick();
            if (hs) check({tag, "_busy_after_last"}, 32'(busy0), 32'd0);
        end
        check({tag, "_drain_timeout"}, 32'(busy0), 32'd0);
    endtask

    task automatic expect_seq(input string tag, input int which);
        int n;
        n = (which == 0) ? got0_d.size() : got1_d.size();
        check({tag, "_count"}, 32'(n), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < n; i++) begin
            if (which == 0) begin
                check($sformatf("%s_data%0d", tag, i), 32'(got0_d[i]), 32'(exp_d[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(got0_l[i]), 32'(exp_l[i]));
            end else begin
                check($sformatf("%s_data%0d", tag, i), 32'(got1_d[i]), 32'(exp_d[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(got1_l[i]), 32'(exp_l[i]));
            end
        end
        got0_d.delete();
        got0_l.delete();
        got1_d.delete();
        got1_l.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got0_d.delete();
        got0_l.delete();
        got1_d.delete();
        got1_l.delete();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        y_in      = '0;
        y_valid   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(o0.out_valid), 32'd0);
        check("rst_out_data", 32'(o0.out_data), 32'd0);
        check("rst_out_last", 32'(o0.out_last), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_overflow", 32'(ovf0), 32'd0);

        // Scenario 1: back-to-back frame, consumer always ready
        out_ready = 1'b1;
        do_start();
        check("s1_busy_after_start", 32'(busy0), 32'd1);
        feed(1, 10, 1'b0);
        drain0("s1");
        build_exp(3, 10, 10);
        expect_seq("s1", 0);
        check("s1_overflow", 32'(ovf0), 32'd0);

        // Scenario 2: consumer stalled, FIFO fills and 7 is dropped
        out_ready = 1'b0;
        do_start();
        feed(1, 7, 1'b0);
        check("s2_out_valid", 32'(o0.out_valid), 32'd1);
        check("s2_head", 32'(o0.out_data), 32'd3);
        check("s2_overflow", 32'(ovf0), 32'd1);
        tick();
        tick();
        check("s2_head_stable", 32'(o0.out_data), 32'd3);
        check("s2_last_stable", 32'(o0.out_last), 32'd0);
        out_ready = 1'b1;
        feed(8, 10, 1'b0);
        drain0("s2");
        build_exp(3, 10, 10);
        exp_d.delete(4);
        exp_l.delete(4);
        expect_seq("s2", 0);
        check("s2_overflow_sticky", 32'(ovf0), 32'd1);

        // Scenario 3: push into a full FIFO while popping
        do_reset();
        check("s3_overflow_cleared", 32'(ovf0), 32'd0);
        out_ready = 1'b0;
        do_start();
        feed(1, 6, 1'b0);
        check("s3_full_head", 32'(o0.out_data), 32'd3);
        y_in      = 16'd7;
        y_valid   = 1'b1;
        out_ready = 1'b1;
        tick();
        y_valid = 1'b0;
        check("s3_head_after_pop", 32'(o0.out_data), 32'd4);
        check("s3_no_overflow", 32'(ovf0), 32'd0);
        feed(8, 10, 1'b0);
        drain0("s3");
        build_exp(3, 10, 10);
        expect_seq("s3", 0);
        check("s3_overflow_end", 32'(ovf0), 32'd0);

        // Scenario 4: y_valid in IDLE ignored, gapped input, start in COLLECT ignored
        y_in    = 16'd99;
        y_valid = 1'b1;
        tick();
        tick();
        tick();
        y_valid = 1'b0;
        check("s4_idle_out_valid", 32'(o0.out_valid), 32'd0);
        check("s4_idle_busy", 32'(busy0), 32'd0);
        do_start();
        for (int v = 1; v <= 10; v++) begin
            y_in    = 16'(v);
            y_valid = 1'b1;
            start   = (v == 6);
            tick();
            y_valid = 1'b0;
            start   = 1'b0;
            tick();
        end
        drain0("s4");
        build_exp(3, 10, 10);
        expect_seq("s4", 0);
        tick();
        tick();
        check("s4_no_extra", 32'(o0.out_valid), 32'd0);

        // Scenario 5: reset mid-frame with two samples queued
        out_ready = 1'b1;
        do_start();
        feed(1, 5, 1'b0);
        tick();
        out_ready = 1'b0;
        feed(6, 7, 1'b0);
        check("s5_queued_head", 32'(o0.out_data), 32'd6);
        build_exp(3, 5, 0);
        expect_seq("s5_pre", 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_rst_out_valid", 32'(o0.out_valid), 32'd0);
        check("s5_rst_busy", 32'(busy0), 32'd0);
        check("s5_rst_overflow", 32'(ovf0), 32'd0);
        check("s5_rst_out_data", 32'(o0.out_data), 32'd0);
        got0_d.delete();
        got0_l.delete();
        got1_d.delete();
        got1_l.delete();
        out_ready = 1'b1;
        do_start();
        feed(1, 10, 1'b0);
        drain0("s5");
        build_exp(3, 10, 10);
        expect_seq("s5", 0);

        // Scenario 6: SKIP=0 instance
        do_reset();
        out_ready = 1'b1;
        do_start();
        check("s6_busy", 32'(busy1), 32'd1);
        feed(1, 8, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (!busy1) break;
            tick();
        end
        check("s6_drain_timeout", 32'(busy1), 32'd0);
        build_exp(1, 8, 8);
        expect_seq("s6", 1);
        check("s6_overflow", 32'(ovf1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_out_collector.md
Name: conv_out_collector

Overview:
- Output-side drain for the 1-D systolic convolution array.
- Consumes the partial-sum stream leaving the last processing element's y output, and discards the pipeline warm-up samples of each frame.
- Buffers valid results in a small FIFO and presents them downstream on a valid/ready interface, with end-of-frame marking.
- Sits between the last PE and the result memory/DMA writer.

Parameters:
- DATA_W, 16, width of y samples and output data.
- SKIP, 2, number of y samples discarded at the start of each frame (array fill latency); 0 allowed.
- FRAME_LEN, 8, number of result samples collected per frame; >= 1.
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- y_in  in  DATA_W  y sample from the last PE.
- y_valid  in  1  y_in holds a new sample this cycle.
- out_data  out  DATA_W  FIFO head sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_last  out  1  head sample is the final sample of the frame.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; skip/collect counters=0; FIFO emptied (pointers and count 0).
  - out_valid=0, out_last=0, out_data=0 (empty-FIFO value forced to 0), busy=0, overflow=0.
  - Reset mid-frame abandons the frame; any FIFO contents are lost.
- States: IDLE, SKIP, COLLECT, DRAIN.
  - IDLE: start=1 -> SKIP (or COLLECT when SKIP==0); counters cleared. y_valid ignored.
  - SKIP: each y_valid increments skip_cnt; the sample is discarded. On the SKIP-th sample -> COLLECT the next cycle.
  - COLLECT: each y_valid is a push attempt {y_in, last}, with last=1 when collect_cnt==FRAME_LEN-1. collect_cnt increments on every attempt, accepted or dropped. After the FRAME_LEN-th attempt -> DRAIN.
  - DRAIN: y_valid ignored. When FIFO empty -> IDLE. This transition can occur in the same cycle as the final pop, so busy falls the cycle after the last handshake.
  - start outside IDLE is ignored (no restart, no error).
- FIFO:
  - out_valid = !empty. out_data and out_last come from registered storage at the read pointer (no combinational path from y_in).
  - Latency: a sample pushed at edge k is presented as head after edge k (visible in cycle k+1) if the FIFO was empty.
  - Pop on out_valid && out_ready.
  - Push while full with a simultaneous pop: accepted, count unchanged.
  - Push while full without a pop: sample dropped, overflow set to 1 and held until rst. The dropped sample still counts toward FRAME_LEN. If the dropped sample was the last one, no out_last is emitted for that frame.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- out_data/out_last hold stable while out_valid=1 and out_ready=0.
- No arithmetic on data; samples pass bit-exact.

Test Plan (SKIP=2, FRAME_LEN=8, FIFO_DEPTH=4):
- rst, start, y_valid=1 for 10 cycles with y_in=1..10, out_ready=1 -> outputs 3,4,...,10 in order, out_last=1 only with 10, overflow=0; busy returns 0 the cycle after the 10 handshake.
- start, out_ready=0, y_in=1..7 consecutively -> FIFO holds 3,4,5,6 (out_valid=1, out_data=3); 7 dropped, overflow=1; raising out_ready yields 3,4,5,6, then 8,9,10 once fed.
- FIFO full (3..6), out_ready=1 in the same cycle y_in=7 arrives -> 3 popped, 7 accepted, no overflow; final sequence 3..10 complete.
- y_valid with gaps (1 on alternate cycles), values 1..10 -> same outputs as scenario 1; start pulsed during COLLECT -> no effect; y_valid pulses in IDLE -> no outputs.
- rst asserted after 5 collected samples with 2 still queued -> next cycle out_valid=0, busy=0, overflow=0; a fresh start with 1..10 produces 3..10 correctly.
- Parameter SKIP=0: start then y_in=1..8 -> outputs 1..8, out_last on 8.
